// File: rtl/led_flash_driver_pkg.sv
// rtl/led_flash_driver_pkg.sv - shared Genius colour, state and timing definitions
package led_flash_driver_pkg;

   // Colour indices shared with the game FSM
   localparam logic [1:0] VERDE    = 2'd0;
   localparam logic [1:0] VERMELHO = 2'd1;
   localparam logic [1:0] AZUL     = 2'd2;
   localparam logic [1:0] AMARELO  = 2'd3;

   // Default timing at 50 MHz: 0.5 s lit, 0.25 s dark
   localparam int DEF_ON_CYCLES  = 25_000_000;
   localparam int DEF_OFF_CYCLES = 12_500_000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } flash_state_t;

   function automatic logic [3:0] led_onehot(input logic [1:0] color);
      logic [3:0] mask;
      case (color)
         VERDE:    mask = 4'b0001;
         VERMELHO: mask = 4'b0010;
         AZUL:     mask = 4'b0100;
         AMARELO:  mask = 4'b1000;
         default:  mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with zero flag
module cycle_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;

   // Holds at zero once expired so an idle owner sees a stable flag
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/led_flash_driver.sv
// rtl/led_flash_driver.sv - turns a start pulse into one timed LED flash plus dark gap
module led_flash_driver
   import led_flash_driver_pkg::*;
#(
   parameter int ON_CYCLES  = DEF_ON_CYCLES,
   parameter int OFF_CYCLES = DEF_OFF_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] color,
   output logic [3:0] leds,
   output logic       busy,
   output logic       done
);

   localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD = (OFF_CYCLES > 0) ? CNT_W'(OFF_CYCLES - 1) : '0;

   flash_state_t     state_q, state_d;
   logic [1:0]       color_q, color_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_zero;

   cycle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_value),
      .zero       (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      color_d   = color_q;
      tmr_load  = 1'b0;
      tmr_value = ON_LOAD;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ON;
               color_d   = color;
               tmr_load  = 1'b1;
               tmr_value = ON_LOAD;
            end
         end
         ST_ON: begin
            if (tmr_zero) begin
               if (OFF_CYCLES > 0) begin
                  state_d   = ST_GAP;
                  tmr_load  = 1'b1;
                  tmr_value = OFF_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are derived from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         color_q <= 2'd0;
         leds    <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         leds    <= (state_d == ST_ON) ? led_onehot(color_d) : 4'b0000;
         busy    <= (state_d != ST_IDLE);
         done    <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_led_flash_driver.sv
// tb/tb_led_flash_driver.sv - randomized self-checking bench for led_flash_driver
module tb_led_flash_driver;

   localparam int ON_C  = 4;
   localparam int OFF_C = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] color;
   logic [3:0] leds_a, leds_b;
   logic       busy_a, busy_b, done_a, done_b;

   int         n_cmp = 0;
   int         n_err = 0;
   int         age_a = 0;
   int         age_b = 0;
   logic [1:0] col_a = 2'd0;
   logic [1:0] col_b = 2'd0;

   always #5 clk = ~clk;

   led_flash_driver #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) u_dut_gap (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .color (color),
      .leds  (leds_a),
      .busy  (busy_a),
      .done  (done_a)
   );

   led_flash_driver #(.ON_CYCLES(ON_C), .OFF_CYCLES(0)) u_dut_nogap (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .color (color),
      .leds  (leds_b),
      .busy  (busy_b),
      .done  (done_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // age = cycles since acceptance (0 = idle); flash occupies ages 1..on+off+1
   task automatic model_edge(input int off, input logic r, input logic s, input logic [1:0] c,
                             inout int age, inout logic [1:0] col);
      if (r) begin
         age = 0;
      end else if (age == 0) begin
         if (s) begin
            age = 1;
            col = c;
         end
      end else if (age == ON_C + off + 1) begin
         age = 0;
      end else begin
         age = age + 1;
      end
   endtask

   function automatic logic [3:0] exp_leds(input int age, input logic [1:0] col);
      logic [3:0] m;
      m = 4'b0001 << col;
      return (age >= 1 && age <= ON_C) ? m : 4'b0000;
   endfunction

   task automatic step(input logic r, input logic s, input logic [1:0] c);
      rst   = r;
      start = s;
      color = c;
      @(posedge clk);
      model_edge(OFF_C, r, s, c, age_a, col_a);
      model_edge(0, r, s, c, age_b, col_b);
      #1;
      check("leds_gap",   {28'd0, leds_a}, {28'd0, exp_leds(age_a, col_a)});
      check("busy_gap",   {31'd0, busy_a}, {31'd0, (age_a != 0)});
      check("done_gap",   {31'd0, done_a}, {31'd0, (age_a == ON_C + OFF_C + 1)});
      check("leds_nogap", {28'd0, leds_b}, {28'd0, exp_leds(age_b, col_b)});
      check("busy_nogap", {31'd0, busy_b}, {31'd0, (age_b != 0)});
      check("done_nogap", {31'd0, done_b}, {31'd0, (age_b == ON_C + 1)});
      @(negedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      color = 2'd0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0);

      // Colour 2 flash with start pulses mid-flight and in the done cycle, then re-accept
      step(1'b0, 1'b1, 2'd2);
      step(1'b0, 1'b0, 2'd2);
      step(1'b0, 1'b1, 2'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b1, 2'd3);
      step(1'b0, 1'b1, 2'd1);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 2'd0);

      // Colour changes after acceptance must not leak into the flash
      step(1'b0, 1'b1, 2'd0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'd3);

      // Reset mid-ON, reset coinciding with start, then a clean start
      step(1'b0, 1'b1, 2'd1);
      step(1'b0, 1'b0, 2'd1);
      step(1'b1, 1'b0, 2'd1);
      step(1'b1, 1'b1, 2'd2);
      step(1'b0, 1'b0, 2'd2);
      step(1'b0, 1'b1, 2'd3);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'd0);

      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
